// File: rtl/br_resolve_arb_if.sv
// Resolution bus between the two branch units and the resolve arbiter.
// Inputs come from BU0/BU1; outputs go to the mask controller and branch stack.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

interface br_resolve_arb_if #(
  parameter int BR_MASK_W = 5,
  parameter int DEPTH     = 4
);
  logic                         br0_valid_i;
  logic                         br0_wrong_i;
  logic [BR_MASK_W-1:0]         br0_bit_i;
  logic [BR_MASK_W-1:0]         br0_dep_mask_i;
  logic                         br1_valid_i;
  logic                         br1_wrong_i;
  logic [BR_MASK_W-1:0]         br1_bit_i;
  logic [BR_MASK_W-1:0]         br1_dep_mask_i;
  logic                         ready_o;
  logic [`BR_STATE_W-1:0]       br_state_o;
  logic [BR_MASK_W-1:0]         br_bit_o;
  logic [BR_MASK_W-1:0]         br_dep_mask_o;
  logic [$clog2(DEPTH+1)-1:0]   count_o;

  modport master (
    output br0_valid_i, br0_wrong_i, br0_bit_i, br0_dep_mask_i,
    output br1_valid_i, br1_wrong_i, br1_bit_i, br1_dep_mask_i,
    input  ready_o, br_state_o, br_bit_o, br_dep_mask_o, count_o
  );

  modport slave (
    input  br0_valid_i, br0_wrong_i, br0_bit_i, br0_dep_mask_i,
    input  br1_valid_i, br1_wrong_i, br1_bit_i, br1_dep_mask_i,
    output ready_o, br_state_o, br_bit_o, br_dep_mask_o, count_o
  );
endinterface

// File: rtl/br_resolve_arb.sv
// Branch resolution arbiter: collapsing age-ordered queue fed by two branch
// units, issuing one resolution per cycle with mispredicts first.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

module br_resolve_arb #(
  parameter int BR_MASK_W = 5,
  parameter int DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst,
  br_resolve_arb_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic                 valid;
    logic                 wrong;
    logic [BR_MASK_W-1:0] br_bit;
    logic [BR_MASK_W-1:0] dep_mask;
  } entry_t;

  typedef enum logic [`BR_STATE_W-1:0] {
    ST_IDLE    = 2'b00,
    ST_CORRECT = `BR_PR_CORRECT,
    ST_WRONG   = `BR_PR_WRONG
  } br_state_e;

  entry_t        q_q [DEPTH];
  entry_t        q_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic                 ready;
  logic                 issue_valid;
  br_state_e            issue_state;
  entry_t               issue_entry;
  logic [IW-1:0]        sel_idx;
  logic [IW-1:0]        first_wrong_idx;
  logic [BR_MASK_W-1:0] wrong_bits;
  logic                 any_wrong;
  logic                 sel_found;

  assign ready = (CW'(DEPTH) - count_q) >= CW'(2);

  // Oldest mispredict: a wrong entry depending on no other queued wrong entry.
  always_comb begin : select
    wrong_bits      = '0;
    any_wrong       = 1'b0;
    sel_found       = 1'b0;
    sel_idx         = '0;
    first_wrong_idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (q_q[i].valid && q_q[i].wrong) begin
        wrong_bits = wrong_bits | q_q[i].br_bit;
        if (!any_wrong) first_wrong_idx = IW'(i);
        any_wrong = 1'b1;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && q_q[i].valid && q_q[i].wrong &&
          ((q_q[i].dep_mask & wrong_bits & ~q_q[i].br_bit) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
    if (any_wrong && !sel_found) sel_idx = first_wrong_idx;
    issue_valid = q_q[0].valid;
    issue_entry = q_q[sel_idx];
    if (!issue_valid)   issue_state = ST_IDLE;
    else if (any_wrong) issue_state = ST_WRONG;
    else                issue_state = ST_CORRECT;
  end

  function automatic entry_t resolve(input entry_t e, input br_state_e st,
                                     input logic [BR_MASK_W-1:0] b);
    entry_t r;
    r = e;
    if (st == ST_WRONG && (e.dep_mask & b) != '0) r.valid = 1'b0;
    else if (st == ST_CORRECT)                    r.dep_mask = e.dep_mask & ~b;
    return r;
  endfunction

  // Resolve, compact survivors in age order, then append surviving inputs.
  always_comb begin : next_state
    entry_t        e;
    logic [CW-1:0] wr;
    wr = '0;
    e  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) q_d[i] = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e = resolve(q_q[i], issue_state, issue_entry.br_bit);
      if (issue_valid && IW'(i) == sel_idx) e.valid = 1'b0;
      if (e.valid && wr < CW'(DEPTH)) begin
        q_d[wr[IW-1:0]] = e;
        wr = wr + CW'(1);
      end
    end
    e.valid    = bus.br0_valid_i & ready;
    e.wrong    = bus.br0_wrong_i;
    e.br_bit   = bus.br0_bit_i;
    e.dep_mask = bus.br0_dep_mask_i;
    e = resolve(e, issue_state, issue_entry.br_bit);
    if (e.valid && wr < CW'(DEPTH)) begin
      q_d[wr[IW-1:0]] = e;
      wr = wr + CW'(1);
    end
    e.valid    = bus.br1_valid_i & ready;
    e.wrong    = bus.br1_wrong_i;
    e.br_bit   = bus.br1_bit_i;
    e.dep_mask = bus.br1_dep_mask_i;
    e = resolve(e, issue_state, issue_entry.br_bit);
    if (e.valid && wr < CW'(DEPTH)) begin
      q_d[wr[IW-1:0]] = e;
      wr = wr + CW'(1);
    end
    count_d = wr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.br_state_o    = issue_state;
  assign bus.br_bit_o      = issue_valid ? issue_entry.br_bit   : '0;
  assign bus.br_dep_mask_o = issue_valid ? issue_entry.dep_mask : '0;
  assign bus.count_o       = count_q;
endmodule

// File: tb/tb_br_resolve_arb.sv
// Bench for br_resolve_arb: queue-level reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'b01
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'b10
`endif

module tb_br_resolve_arb;
  localparam int W = 5;
  localparam int D = 4;
  localparam logic [1:0] S_I = 2'b00;
  localparam logic [1:0] S_C = `BR_PR_CORRECT;
  localparam logic [1:0] S_W = `BR_PR_WRONG;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  br_resolve_arb_if #(.BR_MASK_W(W), .DEPTH(D)) bus ();
  br_resolve_arb #(.BR_MASK_W(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending resolutions as an age-ordered queue.
  typedef struct {
    logic         wrong;
    logic [W-1:0] b;
    logic [W-1:0] dep;
  } ment_t;
  ment_t mq[$];
  ment_t nq[$];
  int           mp;
  logic         mw;
  logic         mc;
  logic [W-1:0] mb;
  logic         macc;

  // Index to issue: oldest mispredict not younger than another queued one.
  function automatic int pick();
    logic [W-1:0] others;
    if (mq.size() == 0) return -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (mq[i].wrong) begin
        others = '0;
        for (int j = 0; j < mq.size(); j++)
          if (j != i && mq[j].wrong) others = others | mq[j].b;
        if ((mq[i].dep & others) == '0) return i;
      end
    end
    return 0;
  endfunction

  function automatic void survive(input ment_t x);
    ment_t y;
    y = x;
    if (mw && (y.dep & mb) != '0) return;
    if (mc) y.dep = y.dep & ~mb;
    nq.push_back(y);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
    end else begin
      mp   = pick();
      mb   = (mp >= 0) ? mq[mp].b : '0;
      mw   = (mp >= 0) && mq[mp].wrong;
      mc   = (mp >= 0) && !mq[mp].wrong;
      macc = (D - mq.size()) >= 2;
      nq.delete();
      for (int i = 0; i < mq.size(); i++)
        if (i != mp) survive(mq[i]);
      if (macc && bus.br0_valid_i)
        survive('{wrong: bus.br0_wrong_i, b: bus.br0_bit_i, dep: bus.br0_dep_mask_i});
      if (macc && bus.br1_valid_i)
        survive('{wrong: bus.br1_wrong_i, b: bus.br1_bit_i, dep: bus.br1_dep_mask_i});
      mq = nq;
    end
  end

  always @(negedge clk) begin
    int p;
    if (!rst) begin
      p = pick();
      if (p < 0) begin
        check("model_state", bus.br_state_o, S_I);
        check("model_bit",   bus.br_bit_o, 0);
        check("model_dep",   bus.br_dep_mask_o, 0);
      end else begin
        check("model_state", bus.br_state_o, mq[p].wrong ? S_W : S_C);
        check("model_bit",   bus.br_bit_o, mq[p].b);
        check("model_dep",   bus.br_dep_mask_o, mq[p].dep);
      end
      check("model_count", bus.count_o, mq.size());
      check("model_ready", bus.ready_o, (D - mq.size()) >= 2);
    end
  end

  task automatic apply(input logic v0, input logic w0, input logic [W-1:0] b0, input logic [W-1:0] d0,
                       input logic v1, input logic w1, input logic [W-1:0] b1, input logic [W-1:0] d1);
    bus.br0_valid_i = v0; bus.br0_wrong_i = w0; bus.br0_bit_i = b0; bus.br0_dep_mask_i = d0;
    bus.br1_valid_i = v1; bus.br1_wrong_i = w1; bus.br1_bit_i = b1; bus.br1_dep_mask_i = d1;
  endtask

  task automatic idle();
    apply(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic [1:0] st, input logic [W-1:0] b,
                            input logic [W-1:0] d, input int cnt, input logic rdy);
    check({name, "_state"}, bus.br_state_o, st);
    check({name, "_bit"},   bus.br_bit_o, b);
    check({name, "_dep"},   bus.br_dep_mask_o, d);
    check({name, "_count"}, bus.count_o, cnt);
    check({name, "_ready"}, bus.ready_o, rdy);
  endtask

  initial begin
    idle();
    #1 rst = 1'b1;
    #1 expect_out("por", S_I, '0, '0, 0, 1);
    @(negedge clk);
    rst = 1'b0;

    // single correct
    apply(1, 0, 5'b00001, 5'b00000, 0, 0, '0, '0); tick();
    expect_out("single_n1", S_C, 5'b00001, 5'b00000, 1, 1);
    idle(); tick();
    expect_out("single_n2", S_I, '0, '0, 0, 1);

    // dual enqueue: br0 older, issued bit cleared from br1's dep
    apply(1, 0, 5'b00001, 5'b00000, 1, 0, 5'b00010, 5'b00001); tick();
    expect_out("dual_a", S_C, 5'b00001, 5'b00000, 2, 1);
    idle(); tick();
    expect_out("dual_b", S_C, 5'b00010, 5'b00000, 1, 1);
    tick();
    expect_out("dual_c", S_I, '0, '0, 0, 1);

    // wrong priority and kill
    apply(1, 0, 5'b01000, 5'b00000, 1, 0, 5'b00100, 5'b00011); tick();
    expect_out("prio_a", S_C, 5'b01000, 5'b00000, 2, 1);
    apply(1, 0, 5'b00001, 5'b00000, 1, 1, 5'b00010, 5'b00001); tick();
    expect_out("prio_b", S_W, 5'b00010, 5'b00001, 3, 0);
    idle(); tick();
    expect_out("prio_c", S_C, 5'b00001, 5'b00000, 1, 1);
    tick();
    expect_out("prio_d", S_I, '0, '0, 0, 1);

    // nested wrongs: younger-looking entry is the true oldest mispredict
    apply(1, 1, 5'b00100, 5'b00011, 1, 1, 5'b00001, 5'b00000); tick();
    expect_out("nest_a", S_W, 5'b00001, 5'b00000, 2, 1);
    idle(); tick();
    expect_out("nest_b", S_I, '0, '0, 0, 1);

    // same-cycle input dropped by a wrong issue
    apply(1, 1, 5'b00001, 5'b00000, 0, 0, '0, '0); tick();
    expect_out("drop_a", S_W, 5'b00001, 5'b00000, 1, 1);
    apply(1, 0, 5'b00010, 5'b00001, 1, 0, 5'b00100, 5'b00000); tick();
    expect_out("drop_b", S_C, 5'b00100, 5'b00000, 1, 1);
    idle(); tick();
    expect_out("drop_c", S_I, '0, '0, 0, 1);

    // same-cycle input dep cleared by a correct issue
    apply(1, 0, 5'b00001, 5'b00000, 0, 0, '0, '0); tick();
    apply(1, 0, 5'b00010, 5'b00001, 0, 0, '0, '0); tick();
    expect_out("clr_a", S_C, 5'b00010, 5'b00000, 1, 1);
    idle(); tick();
    expect_out("clr_b", S_I, '0, '0, 0, 1);

    // backpressure: held inputs accepted only once count falls to 2
    apply(1, 0, 5'b00001, 5'b00000, 1, 0, 5'b00010, 5'b00000); tick();
    expect_out("bp_a", S_C, 5'b00001, 5'b00000, 2, 1);
    apply(1, 0, 5'b00100, 5'b00000, 1, 0, 5'b01000, 5'b00000); tick();
    expect_out("bp_b", S_C, 5'b00010, 5'b00000, 3, 0);
    apply(1, 0, 5'b10000, 5'b00000, 1, 0, 5'b00001, 5'b00000); tick();
    expect_out("bp_c", S_C, 5'b00100, 5'b00000, 2, 1);
    tick();
    expect_out("bp_d", S_C, 5'b01000, 5'b00000, 3, 0);
    idle(); tick();
    expect_out("bp_e", S_C, 5'b10000, 5'b00000, 2, 1);
    tick();
    expect_out("bp_f", S_C, 5'b00001, 5'b00000, 1, 1);
    tick();
    expect_out("bp_g", S_I, '0, '0, 0, 1);

    // asynchronous reset mid-cycle with three entries queued
    apply(1, 0, 5'b00001, 5'b00000, 1, 0, 5'b00010, 5'b00000); tick();
    apply(1, 0, 5'b00100, 5'b00000, 1, 0, 5'b01000, 5'b00000); tick();
    expect_out("rst_pre", S_C, 5'b00010, 5'b00000, 3, 0);
    idle();
    #2 rst = 1'b1;
    #1 expect_out("rst_async", S_I, '0, '0, 0, 1);
    #1 rst = 1'b0;
    tick();
    expect_out("rst_post", S_I, '0, '0, 0, 1);
    apply(0, 0, '0, '0, 1, 1, 5'b00010, 5'b00000); tick();
    expect_out("rst_new", S_W, 5'b00010, 5'b00000, 1, 1);
    idle(); tick();
    expect_out("rst_end", S_I, '0, '0, 0, 1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/br_resolve_arb.md
Name: br_resolve_arb

Overview:
- Arbitrates branch resolutions from two branch execution units into the single resolution port of the branch mask controller and branch stack.
- Buffers pending resolutions in a small collapsing queue and issues at most one per cycle.
- Gives mispredictions priority over correct resolutions.
- On issue, squashes queued resolutions killed by a mispredict and clears freed mask bits so a reallocated bit never aliases.

Parameters:
- BR_MASK_W, 5, branch mask width (one bit per in-flight branch).
- DEPTH, 4, pending-resolution queue entries (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- br0_valid_i  in  1  BU0 resolution valid
- br0_wrong_i  in  1  BU0 prediction wrong
- br0_bit_i  in  BR_MASK_W  one-hot mask bit owned by BU0's branch
- br0_dep_mask_i  in  BR_MASK_W  mask the BU0 branch depends on (older in-flight branches)
- br1_valid_i, br1_wrong_i, br1_bit_i, br1_dep_mask_i  in  1/1/BR_MASK_W/BR_MASK_W  same for BU1
- ready_o  out  1  both BUs may present a resolution this cycle
- br_state_o  out  `BR_STATE_W  2'b00 idle, `BR_PR_CORRECT or `BR_PR_WRONG
- br_bit_o  out  BR_MASK_W  one-hot bit of the issued branch; 0 when idle
- br_dep_mask_o  out  BR_MASK_W  current (bit-cleared) dep mask of the issued branch; 0 when idle
- count_o  out  $clog2(DEPTH+1)  valid queue entries

Behaviour:
- Reset (async, rst=1): queue empty, count_o=0, br_state_o=0, br_bit_o=0, br_dep_mask_o=0, ready_o=1. Reset mid-operation discards all entries immediately.
- Entry: {valid, wrong, bit, dep_mask}. Entries are kept in age order; index 0 is oldest.
- Enqueue at posedge when valid_i=1 and ready_o=1. Valid inputs with ready_o=0 are lost; BUs must hold them. If both inputs enqueue, br0 takes the older slot.
- ready_o = (DEPTH - count) >= 2. This is registered-state based.
- Latency: a resolution accepted at edge N is visible on the outputs no earlier than cycle N+1. There is no input-to-output combinational path.
- Issue selection, combinational from queue state, one per cycle, held for one cycle:
  - If any valid wrong entry exists: issue the lowest-index wrong entry whose dep_mask has no overlap with the bit of any other valid wrong entry (the oldest mispredict).
  - Otherwise issue entry 0.
  - If the queue is empty: outputs idle (all zero).
- Effects at the edge ending an issue cycle, with issued bit b:
  - WRONG: every queued entry, and every same-cycle input, with dep_mask & b != 0 is removed or dropped. The issued entry is removed.
  - CORRECT: every queued entry and every same-cycle input has dep_mask &= ~b. The issued entry is removed.
- Update order within one edge:
  1. Apply issue effects to surviving queue entries and incoming entries.
  2. Compact the queue, preserving order.
  3. Append surviving inputs (br0 then br1).
- Dropped inputs still count as accepted. The upstream handshake is unaffected.
- count_o reflects the post-edge occupancy.
- Simultaneous equal bits from both BUs are illegal upstream; behaviour is unspecified.
- An input whose bit equals the issued wrong bit b cannot occur, since resolution is unique.

Test Plan:
- Reset: assert rst asynchronously mid-clock with 3 entries queued -> count_o=0, br_state_o=0, br_bit_o=0 and ready_o=1 immediately, before the next edge.
- Single correct: br0 valid, correct, bit=00001, dep=00000 at edge N -> cycle N+1 shows state=CORRECT, bit=00001, dep=00000; cycle N+2 idle, count_o=0.
- Dual enqueue order: br0 bit=00001 and br1 bit=00010 (dep=00001), both correct, same edge -> issues 00001 with dep 00000, then 00010 with dep 00000 (bit 0 cleared).
- Wrong priority and kill: queue holds correct bit=00100 (dep=00011), correct bit=00001 (dep=0), and wrong bit=00010 (dep=00001) -> wrong 00010 issues first; the 00100 entry is squashed; then correct 00001 issues; queue empty.
- Nested wrongs: wrong bit=00100 (dep=00011) enqueued before wrong bit=00001 (dep=0) -> 00001 issues first, 00100 is squashed, one issue total.
- Backpressure: with DEPTH=4 and no issue possible, three accepted entries -> ready_o=0 while count_o>=3; held inputs are accepted only after count_o drops to 2.
